// File: rtl/pes_rr_arbiter_n_pkg.sv
// Shared types and helpers for the round-robin arbiter family.
package pes_arb_pkg;

  localparam int unsigned HOLD_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Width of an encoded index for n requesters, never less than one bit.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pes_rr_arbiter_n_pick.sv
// Rotating priority encoder: first set bit of ereq at or after start, with wrap.
module pes_rr_pick
  import pes_arb_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = clog2w(N)
) (
  input  logic [N-1:0]   ereq,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   win,
  output logic [IDW-1:0] win_id,
  output logic           any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;

  assign dbl = {ereq, ereq};
  assign rot = dbl >> start;

  // Scan the rotated copy upward; the first hit is the winner.
  always_comb begin
    int unsigned pos;
    win    = '0;
    win_id = '0;
    any    = 1'b0;
    pos    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        pos = 32'(start) + k;
        if (pos >= N) pos = pos - N;
        win_id = IDW'(pos);
        win    = N'(1) << win_id;
      end
    end
  end

endmodule

// File: rtl/pes_rr_arbiter_n.sv
// N-way round-robin bus arbiter with masking, encoded grant and tenure limit.
module pes_rr_arbiter_n
  import pes_arb_pkg::*;
#(
  parameter  int unsigned N        = 4,
  parameter  int unsigned MAX_HOLD = 8,
  localparam int unsigned IDW      = clog2w(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N-1:0]          req_mask,
  output logic [N-1:0]          gnt,
  output logic [IDW-1:0]        gnt_id,
  output logic                  gnt_vld,
  output logic [HOLD_CNT_W-1:0] hold_cnt
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_LIM  = HOLD_CNT_W'(MAX_HOLD);
  localparam bit                    UNLIMITED = (MAX_HOLD == 0);
  localparam logic [IDW-1:0]        LAST      = IDW'(N - 1);

  arb_state_t            state, state_nxt;
  logic [N-1:0]          ereq;
  logic [N-1:0]          gnt_nxt;
  logic [IDW-1:0]        id_nxt;
  logic [IDW-1:0]        ptr, ptr_nxt;
  logic [IDW-1:0]        start;
  logic [HOLD_CNT_W-1:0] hold_nxt;
  logic [N-1:0]          win;
  logic [IDW-1:0]        win_id;
  logic                  any;
  logic                  own_req;
  logic                  keep;

  assign ereq    = req & ~req_mask;
  assign own_req = |(ereq & gnt);
  assign keep    = (state == OWNED) && own_req && (UNLIMITED || (hold_cnt < HOLD_LIM));
  assign start   = (ptr == LAST) ? '0 : ptr + 1'b1;
  assign gnt_vld = (state == OWNED);

  pes_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .ereq   (ereq),
    .start  (start),
    .win    (win),
    .win_id (win_id),
    .any    (any)
  );

  // Next-state: keep the tenure, or re-arbitrate from the slot after the last
  // owner. Release, expiry and idle arbitration all share one scan: the owner
  // sits last in the scan order, so it re-wins only when nobody else is eligible.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    id_nxt    = gnt_id;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    if (keep) begin
      if (hold_cnt != '1) hold_nxt = hold_cnt + 1'b1;
    end else if (any) begin
      state_nxt = OWNED;
      gnt_nxt   = win;
      id_nxt    = win_id;
      ptr_nxt   = win_id;
      hold_nxt  = HOLD_CNT_W'(1);
    end else begin
      state_nxt = IDLE;
      gnt_nxt   = '0;
      id_nxt    = '0;
      hold_nxt  = '0;
    end
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= LAST;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_vld    : assert property (@(posedge clk) disable iff (!rst) gnt_vld == (|gnt));
  a_id     : assert property (@(posedge clk) disable iff (!rst)
                              !gnt_vld || (gnt == (N'(1) << gnt_id)));

endmodule

// File: doc/pes_rr_arbiter_n.md
Name: pes_rr_arbiter_n

Overview:
Parametrised N-requester round-robin bus arbiter, the successor to the fixed 4-way arbiter. It adds the following on top of the 4-way arbiter's behaviour:
- configurable requester count;
- per-requester mask;
- encoded grant plus valid;
- a bounded hold (tenure) counter that forces rotation so one requester cannot monopolise the bus.

It sits between N bus masters and a shared bus/slave port. The existing "hold the grant while the owner keeps requesting" bus-lock semantics are kept.

Parameters:
- N, 4, number of requesters; legal range 1..32.
- MAX_HOLD, 8, max consecutive granted cycles per tenure; 0 = unlimited (pure lock-until-release).
- IDW, max(1,$clog2(N)), width of encoded grant id; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk by the system.
- req  in  N  request vector, bit i = requester i.
- req_mask  in  N  1 = requester i is ignored (treated as not requesting).
- gnt  out  N  one-hot (or zero) registered grant.
- gnt_id  out  IDW  binary index of granted requester; valid only when gnt_vld = 1.
- gnt_vld  out  1  1 when any gnt bit is set.
- hold_cnt  out  8  cycles the current owner has held the grant, saturating at 255.

Behaviour:
- Effective request: ereq = req & ~req_mask.
- All outputs registered. Reset values:
  - gnt = 0, gnt_id = 0, gnt_vld = 0, hold_cnt = 0.
  - Internal last-owner pointer = N-1, so requester 0 has first priority after reset.
- States:
  - IDLE (gnt_vld = 0).
  - OWNED (gnt_vld = 1, owner = gnt_id).
- Latency: ereq sampled in cycle t produces gnt in cycle t+1. There is no combinational path from req to gnt.
- IDLE:
  - If ereq != 0, pick the first set bit scanning from (ptr+1) mod N upward with wrap-around.
  - Grant it next cycle, set ptr := winner, hold_cnt := 1, go to OWNED.
  - Else stay in IDLE.
- OWNED, keep condition: ereq[owner] = 1 and (MAX_HOLD = 0 or hold_cnt < MAX_HOLD). Then retain the grant and increment hold_cnt (saturating).
- OWNED, owner release: ereq[owner] = 0, whether by deasserting req or by setting the mask.
  - Arbitrate among ereq in the same cycle, starting the scan at owner+1.
  - If there is a winner, the new grant appears in the next cycle with no idle bubble, and hold_cnt := 1.
  - If there is no winner, go to IDLE and clear gnt.
- OWNED, tenure expiry: ereq[owner] = 1 and hold_cnt = MAX_HOLD.
  - If any other ereq bit is set, rotate to the next requester after owner and set hold_cnt := 1.
  - If only the owner requests, the owner retains the grant and hold_cnt restarts at 1. No bubble.
- The owner never re-wins in the same arbitration it released or expired in while any other requester is eligible. This is the fairness guarantee.
- Fairness bound: with all N requesting and MAX_HOLD = H, each requester waits at most (N-1)·H cycles.
- gnt is always one-hot or zero, and gnt_id/gnt_vld are always consistent with gnt. Both are assertion-checked.
- Mask changes take effect in the next arbitration. A masked owner is released on the next edge.
- N = 1: gnt[0] follows ereq[0] one cycle late, with tenure restarts only. gnt_id is tied to 0.
- Reset asserted mid-tenure: outputs clear asynchronously. After deassertion, arbitration restarts from requester 0.

Decomposition:
- Shared package pes_arb_pkg:
  - function clog2w(n), which returns max(1,$clog2(n));
  - HOLD_CNT_W = 8 constant;
  - arb_state_t enum {IDLE, OWNED}.
- One combinational sub-module pes_rr_pick (params N, IDW):
  - inputs: vector ereq and start index;
  - outputs: winner one-hot, winner id, any;
  - implementation: rotating priority encoder built as a double-width vector scan.
- The top module holds the state register, pointer, hold counter and output registers.

Test Plan (N=4, MAX_HOLD=4 unless noted):
- Reset then req=4'b1111 held: gnt=0001 for 4 cycles, then 0010 ×4, 0100 ×4, 1000 ×4, then 0001. hold_cnt runs 1..4 on each tenure; no bubble cycles.
- After reset, req=4'b0100 for 2 cycles, then req=4'b1001: gnt=0100 in cycles 1–2, then 1000 (scan starts at 3), then 0001 after req3 drops. gnt_id = 2, 3, 0.
- req=0010 alone held 10 cycles: gnt=0010 throughout, and hold_cnt wraps 1,2,3,4,1,2. Then assert req_mask=0010 → gnt=0 and gnt_vld=0 next cycle.
- MAX_HOLD=0, req0 held 300 cycles while req1 is also high: gnt stays 0001 with hold_cnt saturating at 255. Dropping req0 gives gnt=0010 next cycle.
- Owner 2 holding, assert rst low mid-cycle: gnt/gnt_vld/hold_cnt go to 0 before the next clk edge. After release with req=1111, the first grant is 0001.
- N=1 and N=5 builds: randomized req/mask for 10k cycles, with assertions on one-hot, id consistency, 1-cycle latency and the (N-1)·MAX_HOLD starvation bound.
